dcache_dm: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate data cache for the execute stage. The load/store unit sends it LDR/STR micro-ops. It holds 2^INDEX_WIDTH single-word lines, answers load hits in one cycle and refills load misses from a backing data memory over a request/acknowledge port. Stores always write through to memory, and a store that hits also updates its cached line with byte-enable merging.

---
 rtl/dcache_dm.sv | 173 +++++++++++++++++
 tb/tb_dcache_dm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with single-word lines.
// Load misses refill over a req/ack memory port; stores always write through.
module dcache_dm #(
    parameter logic [3:0] STR_UOP     = 4'b1001,
    parameter logic [3:0] LDR_UOP     = 4'b1010,
    parameter int         ADDR_WIDTH  = 16,
    parameter int         DATA_WIDTH  = 32,
    parameter int         INDEX_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [3:0]              uop,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    mem_req_valid,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH;
    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LINES-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES];

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_data_out;

    logic [INDEX_WIDTH-1:0] w_idx;
    logic [TAG_WIDTH-1:0]   w_tag;
    logic [INDEX_WIDTH-1:0] w_ridx;
    logic [TAG_WIDTH-1:0]   w_rtag;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_is_ld;
    logic                   w_is_st;
    logic                   w_refill_done;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_idx    = addr[INDEX_WIDTH-1:0];
    assign w_tag    = addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_ridx   = r_addr[INDEX_WIDTH-1:0];
    assign w_rtag   = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign req_ready     = (r_state == S_IDLE) && !flush;
    assign w_accept      = req_valid && req_ready;
    assign w_is_ld       = w_accept && (uop == LDR_UOP);
    assign w_is_st       = w_accept && (uop == STR_UOP);
    assign w_refill_done = (r_state == S_REFILL) && mem_ack;

    assign resp_valid  = r_resp_valid;
    assign data_out    = r_data_out;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_byte_en = r_be;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        mem_req_valid = 1'b0;
        mem_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_ld && !w_hit) w_state_next = S_REFILL;
                else if (w_is_st)      w_state_next = S_WRITE;
            end
            S_REFILL: begin
                mem_req_valid = 1'b1;
                if (mem_ack) w_state_next = S_IDLE;
            end
            S_WRITE: begin
                mem_req_valid = 1'b1;
                mem_we        = 1'b1;
                if (mem_ack) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid      <= '0;
            r_resp_valid <= 1'b0;
            r_data_out   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_is_ld) begin
                        if (w_hit) begin
                            r_data_out   <= r_data[w_idx];
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_addr <= addr;
                        end
                    end else if (w_is_st) begin
                        r_addr  <= addr;
                        r_wdata <= data_in;
                        r_be    <= byte_en;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_valid[w_ridx] <= 1'b1;
                        r_data_out      <= mem_rdata;
                        r_resp_valid    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) r_resp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage carries no reset; the valid bits alone gate its use.
    always_ff @(posedge clock) begin
        if (w_refill_done) begin
            r_tag[w_ridx]  <= w_rtag;
            r_data[w_ridx] <= mem_rdata;
        end else if (w_is_st && w_hit) begin
            r_data[w_idx] <= f_merge(r_data[w_idx], data_in, byte_en);
        end
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Bench for dcache_dm: directed plan steps then random LDR/STR traffic,
// checked against a word-level memory model plus a per-index record of cached addresses.
module tb_dcache_dm;

    localparam logic [3:0] STR = 4'b1001;
    localparam logic [3:0] LDR = 4'b1010;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  uop = 4'h0;
    logic [15:0] addr = 16'h0;
    logic [31:0] data_in = 32'h0;
    logic [3:0]  byte_en = 4'h0;
    logic        resp_valid;
    logic [31:0] data_out;
    logic        mem_req_valid;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:65535];
    int          cached [0:31];
    logic [31:0] last_dout;

    dcache_dm dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .uop(uop),
        .addr(addr), .data_in(data_in), .byte_en(byte_en),
        .resp_valid(resp_valid), .data_out(data_out),
        .mem_req_valid(mem_req_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++) cached[k] = -1;
    endtask

    // One idle cycle with a stray mem_ack that the cache must ignore.
    task automatic idle_gap();
        mem_ack = 1'b1;
        mem_rdata = $urandom;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        chk("idle_resp", resp_valid, 1'b0);
        chk("idle_mreq", mem_req_valid, 1'b0);
        chk("idle_dout", data_out, last_dout);
    endtask

    task automatic wait_ack(input int dly, input logic [15:0] a, input logic we, input logic [31:0] rd);
        for (int k = 0; k < dly; k++) begin
            @(negedge clock);
            mem_ack = 1'b0;
            chk("hold_mreq", mem_req_valid, 1'b1);
            chk("hold_maddr", mem_addr, a);
            chk("hold_mwe", mem_we, we);
            chk("hold_resp", resp_valid, 1'b0);
            @(posedge clock);
        end
        @(negedge clock);
        mem_ack = 1'b1;
        mem_rdata = rd;
        @(posedge clock); #1;
        mem_ack = 1'b0;
        mem_rdata = $urandom;
    endtask

    task automatic ld(input logic [15:0] a, input int dly);
        int i;
        bit hit;
        i = int'(a[4:0]);
        hit = (cached[i] == int'(a));
        @(negedge clock);
        uop = LDR; addr = a; req_valid = 1'b1;
        #1 chk("ld_ready", req_ready, 1'b1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        if (hit) begin
            chk("hit_resp", resp_valid, 1'b1);
            chk("hit_data", data_out, mem[a]);
            chk("hit_nomreq", mem_req_valid, 1'b0);
        end else begin
            chk("miss_mreq", mem_req_valid, 1'b1);
            chk("miss_mwe", mem_we, 1'b0);
            chk("miss_maddr", mem_addr, a);
            chk("miss_resp", resp_valid, 1'b0);
            chk("miss_busy", req_ready, 1'b0);
            wait_ack(dly, a, 1'b0, mem[a]);
            chk("refill_resp", resp_valid, 1'b1);
            chk("refill_data", data_out, mem[a]);
            chk("refill_ready", req_ready, 1'b1);
            chk("refill_mreq", mem_req_valid, 1'b0);
            cached[i] = int'(a);
        end
        last_dout = mem[a];
        idle_gap();
    endtask

    task automatic st(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be, input int dly);
        @(negedge clock);
        uop = STR; addr = a; data_in = d; byte_en = be; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        data_in = $urandom; byte_en = 4'($urandom);
        chk("st_mreq", mem_req_valid, 1'b1);
        chk("st_mwe", mem_we, 1'b1);
        chk("st_maddr", mem_addr, a);
        chk("st_wdata", mem_wdata, d);
        chk("st_be", mem_byte_en, be);
        chk("st_resp", resp_valid, 1'b0);
        wait_ack(dly, a, 1'b1, $urandom);
        chk("st_done_resp", resp_valid, 1'b1);
        chk("st_done_dout", data_out, last_dout);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[a][b*8 +: 8] = d[b*8 +: 8];
        end
        idle_gap();
    endtask

    task automatic other(input logic [3:0] u, input logic [15:0] a);
        @(negedge clock);
        uop = u; addr = a; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("other_resp", resp_valid, 1'b0);
        chk("other_mreq", mem_req_valid, 1'b0);
        chk("other_ready", req_ready, 1'b1);
    endtask

    task automatic flush_req(input logic [15:0] a);
        @(negedge clock);
        flush = 1'b1; uop = LDR; addr = a; req_valid = 1'b1;
        #1 chk("flush_ready", req_ready, 1'b0);
        @(posedge clock); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_resp", resp_valid, 1'b0);
        chk("flush_mreq", mem_req_valid, 1'b0);
        clear_model();
    endtask

    initial begin
        logic [15:0] ra;
        int r;
        for (int k = 0; k < 65536; k++) mem[k] = $urandom;
        mem[16'h0021] = 32'hDEADBEEF;
        clear_model();
        last_dout = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp", resp_valid, 1'b0);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_mreq", mem_req_valid, 1'b0);
        chk("rst_mwe", mem_we, 1'b0);
        chk("rst_maddr", mem_addr, 16'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", mem_byte_en, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1 chk("rst_ready", req_ready, 1'b1);

        ld(16'h0021, 3);
        chk("plan_refill_val", data_out, 32'hDEADBEEF);
        ld(16'h0021, 0);
        st(16'h0021, 32'h11223344, 4'b0011, 1);
        ld(16'h0021, 0);
        chk("plan_merge_val", data_out, 32'hDEAD3344);
        st(16'h0042, $urandom, 4'b1111, 0);
        ld(16'h0042, 2);
        st(16'h0021, $urandom, 4'b0000, 2);
        ld(16'h0041, 1);
        ld(16'h0021, 0);
        ld(16'h0022, 0);

        @(negedge clock);
        uop = LDR; addr = 16'h0021; req_valid = 1'b1;
        @(posedge clock); #1;
        chk("b2b_resp0", resp_valid, 1'b1);
        chk("b2b_data0", data_out, mem[16'h0021]);
        chk("b2b_ready", req_ready, 1'b1);
        addr = 16'h0022;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("b2b_resp1", resp_valid, 1'b1);
        chk("b2b_data1", data_out, mem[16'h0022]);
        chk("b2b_mreq", mem_req_valid, 1'b0);
        last_dout = mem[16'h0022];
        idle_gap();

        other(4'b0000, 16'h0021);
        other(4'b1011, 16'h0099);
        flush_req(16'h0021);
        ld(16'h0021, 1);

        @(negedge clock);
        uop = LDR; addr = 16'h0033; req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("abort_mreq_on", mem_req_valid, 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_mreq_off", mem_req_valid, 1'b0);
        chk("abort_resp", resp_valid, 1'b0);
        chk("abort_dout", data_out, 32'h0);
        mem_ack = 1'b1;
        mem_rdata = mem[16'h0033];
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mem_ack = 1'b0;
        clear_model();
        last_dout = 32'h0;
        @(posedge clock); #1;
        chk("abort_idle_resp", resp_valid, 1'b0);
        chk("abort_idle_ready", req_ready, 1'b1);
        chk("abort_idle_mreq", mem_req_valid, 1'b0);
        ld(16'h0033, 1);
        ld(16'h0021, 0);

        for (int n = 0; n < 80; n++) begin
            ra = 16'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 5) begin
                ld(ra, $urandom_range(0, 3));
            end else if (r < 9) begin
                st(ra, $urandom, 4'($urandom), $urandom_range(0, 3));
            end else if ($urandom_range(0, 1) == 0) begin
                other(4'($urandom_range(0, 8)), ra);
            end else begin
                flush_req(ra);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
